// File: rtl/cordic_stage_hs.sv
// cordic_stage_hs: one CORDIC micro-rotation stage with a valid/ready handshake
// and a 2-entry (main + skid) output buffer. Rotation and vectoring modes.
// Optional macro CORDIC_ROUND_EN: shifted terms use round-half-up instead of
// plain truncation.
module cordic_stage_hs #(
    parameter int              WIDTH = 32,
    parameter int              SHIFT = 6,
    parameter logic [WIDTH-1:0] ATAN = WIDTH'(32'h00FFFAAB)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] x_in,
    input  logic signed [WIDTH-1:0] y_in,
    input  logic signed [WIDTH-1:0] z_in,
    input  logic                    mode_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] x_out,
    output logic signed [WIDTH-1:0] y_out,
    output logic signed [WIDTH-1:0] z_out,
    output logic                    mode_out
);

`ifdef CORDIC_ROUND_EN
    localparam int HSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic signed [WIDTH:0] HALF = (WIDTH+1)'(1) << HSH;
`endif

    // Shifted term x>>>SHIFT / y>>>SHIFT; large shifts collapse to the sign fill.
    function automatic logic signed [WIDTH-1:0] shr_term(input logic signed [WIDTH-1:0] v);
`ifdef CORDIC_ROUND_EN
        logic signed [WIDTH:0] ext;
        if (SHIFT == 0) return v;
        ext = $signed({v[WIDTH-1], v}) + HALF;
        ext = ext >>> SHIFT;
        return ext[WIDTH-1:0];
`else
        return v >>> SHIFT;
`endif
    endfunction

    logic                    rdy_q;
    logic                    vld_p1, skid_vld;
    logic signed [WIDTH-1:0] x_p0, y_p0, z_p0;
    logic signed [WIDTH-1:0] x_p1, y_p1, z_p1, x_sk, y_sk, z_sk;
    logic                    mode_p1, mode_sk;
    logic                    d_pos, acc, main_free, take_new, take_skid, to_skid;
    logic signed [WIDTH-1:0] xs, ys;

    // Stage p0: direction decision and micro-rotation on the incoming sample.
    always_comb begin
        xs    = shr_term(x_in);
        ys    = shr_term(y_in);
        d_pos = mode_in ? y_in[WIDTH-1] : (!z_in[WIDTH-1] && (|z_in));
        if (d_pos) begin
            x_p0 = x_in - ys;
            y_p0 = y_in + xs;
            z_p0 = z_in - $signed(ATAN);
        end else begin
            x_p0 = x_in + ys;
            y_p0 = y_in - xs;
            z_p0 = z_in + $signed(ATAN);
        end
    end

    // Handshake decode: where the accepted sample (or the skid entry) goes this cycle.
    always_comb begin
        acc       = in_valid && rdy_q;
        main_free = !vld_p1 || out_ready;
        take_skid = main_free && skid_vld;
        take_new  = main_free && !skid_vld && acc;
        to_skid   = !main_free && acc;
    end

    // Control state: valids and the registered ready flag; only these see reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            skid_vld <= 1'b0;
            rdy_q    <= 1'b0;
        end else begin
            if (main_free) vld_p1 <= skid_vld || acc;
            if (take_skid) skid_vld <= 1'b0;
            else if (to_skid) skid_vld <= 1'b1;
            rdy_q <= !(to_skid || (skid_vld && !take_skid));
        end
    end

    // Stage p1: main and skid data registers, loaded by the decoded enables.
    always_ff @(posedge clk) begin
        if (take_new) begin
            x_p1 <= x_p0; y_p1 <= y_p0; z_p1 <= z_p0; mode_p1 <= mode_in;
        end else if (take_skid) begin
            x_p1 <= x_sk; y_p1 <= y_sk; z_p1 <= z_sk; mode_p1 <= mode_sk;
        end
        if (to_skid) begin
            x_sk <= x_p0; y_sk <= y_p0; z_sk <= z_p0; mode_sk <= mode_in;
        end
    end

    // Outputs read zero whenever nothing valid is held, which covers reset.
    always_comb begin
        in_ready  = rdy_q;
        out_valid = vld_p1;
        x_out     = vld_p1 ? x_p1 : '0;
        y_out     = vld_p1 ? y_p1 : '0;
        z_out     = vld_p1 ? z_p1 : '0;
        mode_out  = vld_p1 ? mode_p1 : 1'b0;
    end

endmodule

// File: tb/tb_cordic_stage_hs.sv
// Scoreboard bench for cordic_stage_hs (WIDTH=32, SHIFT=6, default ATAN).
module tb_cordic_stage_hs;
    localparam int W = 32;

    typedef struct packed {
        logic signed [W-1:0] x;
        logic signed [W-1:0] y;
        logic signed [W-1:0] z;
        logic                m;
    } smp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic signed [W-1:0] x_in = '0, y_in = '0, z_in = '0;
    logic signed [W-1:0] x_out, y_out, z_out;
    logic mode_in = 1'b0, mode_out;

    int checks = 0;
    int failures = 0;
    smp_t exp_q[$];

    cordic_stage_hs dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .mode_in(mode_in),
        .out_valid(out_valid), .out_ready(out_ready),
        .x_out(x_out), .y_out(y_out), .z_out(z_out), .mode_out(mode_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference micro-rotation (SHIFT=6, ATAN=0x00FFFAAB) for the streaming test.
    function automatic smp_t model(input smp_t s);
        smp_t r;
        logic signed [W-1:0] tx, ty;
        bit dp;
`ifdef CORDIC_ROUND_EN
        tx = W'((64'(s.x) + 64'sd32) >>> 6);
        ty = W'((64'(s.y) + 64'sd32) >>> 6);
`else
        tx = s.x >>> 6;
        ty = s.y >>> 6;
`endif
        dp = s.m ? (s.y < 0) : (s.z > 0);
        r.x = dp ? s.x - ty : s.x + ty;
        r.y = dp ? s.y + tx : s.y - tx;
        r.z = dp ? s.z - 32'sh00FFFAAB : s.z + 32'sh00FFFAAB;
        r.m = s.m;
        return r;
    endfunction

    // Drive one sample and wait (bounded) for acceptance; push its expectation.
    task automatic send(input smp_t s, input smp_t e);
        bit acc;
        int n;
        x_in = s.x; y_in = s.y; z_in = s.z; mode_in = s.m; in_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk); #1;
            n++;
        end while (!acc && n < 50);
        if (acc) exp_q.push_back(e);
        else check("accept_timeout", 32'(n), 32'd0);
    endtask

    // Monitor: pop and compare on every output transfer; check hold while stalled.
    smp_t prev;
    bit prev_stall = 1'b0;
    always @(negedge clk) begin
        smp_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall && out_valid) begin
                check("hold_x", x_out, prev.x);
                check("hold_z", z_out, prev.z);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("x_out", x_out, e.x);
                    check("y_out", y_out, e.y);
                    check("z_out", z_out, e.z);
                    check("mode_out", 32'(mode_out), 32'(e.m));
                end
            end
            prev_stall = out_valid && !out_ready;
            prev = '{x_out, y_out, z_out, mode_out};
        end
    end

    initial begin
        smp_t s, e;
        int n;
        // Reset with in_valid held high.
        in_valid = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_x_out", x_out, 32'd0);
        check("rst_y_out", y_out, 32'd0);
        check("rst_z_out", z_out, 32'd0);
        check("rst_mode_out", 32'(mode_out), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(posedge clk); #1;
        check("in_ready_after_rst", 32'(in_ready), 32'd1);
        check("no_spurious_valid", 32'(out_valid), 32'd0);

        // Directed vectors.
        send('{32'sd65536, 32'sd0, 32'sd100, 1'b0}, '{32'sd65536, 32'sd1024, -32'sd16775751, 1'b0});
        send('{32'sd65536, -32'sd6400, 32'sd0, 1'b1}, '{32'sd65636, -32'sd5376, -32'sd16775851, 1'b1});
        send('{32'sd64, 32'sd0, 32'sd0, 1'b0}, '{32'sd64, -32'sd1, 32'sd16775851, 1'b0});
`ifdef CORDIC_ROUND_EN
        send('{32'sh7FFFFFC0, 32'sh7FFFFFFF, 32'sd1, 1'b0}, '{32'sh7DFFFFC0, 32'sh81FFFFFE, 32'shFF000556, 1'b0});
        send('{32'sd63, 32'sd0, 32'sd1, 1'b0}, '{32'sd63, 32'sd1, 32'shFF000556, 1'b0});
`else
        send('{32'sh7FFFFFC0, 32'sh7FFFFFFF, 32'sd1, 1'b0}, '{32'sh7DFFFFC1, 32'sh81FFFFFE, 32'shFF000556, 1'b0});
        send('{32'sd63, 32'sd0, 32'sd1, 1'b0}, '{32'sd63, 32'sd0, 32'shFF000556, 1'b0});
`endif
        in_valid = 1'b0;
        repeat (3) @(posedge clk); #1;

        // Back-pressure: 10 streamed samples, out_ready low for cycles 3-7.
        fork
            begin
                for (int k = 0; k < 10; k++) begin
                    s.x = 32'(1000 * (k + 1));
                    s.y = 32'(300 - 500 * k);
                    s.z = (k % 2 == 1) ? 32'sd5000 : -32'sd5000;
                    s.m = (k % 3 == 0);
                    send(s, model(s));
                end
                in_valid = 1'b0;
            end
            begin
                out_ready = 1'b1;
                repeat (2) begin @(posedge clk); #1; end
                out_ready = 1'b0;
                repeat (2) begin @(posedge clk); #1; end
                check("in_ready_low_in_stall", 32'(in_ready), 32'd0);
                check("out_valid_in_stall", 32'(out_valid), 32'd1);
                repeat (3) begin @(posedge clk); #1; end
                out_ready = 1'b1;
            end
        join
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("stream_drained", 32'(exp_q.size()), 32'd0);
        @(posedge clk); #1;
        check("idle_after_stream", 32'(out_valid), 32'd0);

        // Reset while skid holds a sample.
        out_ready = 1'b0;
        send('{32'sd1, 32'sd2, 32'sd3, 1'b0}, '{32'sd0, 32'sd0, 32'sd0, 1'b0});
        send('{32'sd4, 32'sd5, 32'sd6, 1'b0}, '{32'sd0, 32'sd0, 32'sd0, 1'b0});
        in_valid = 1'b0;
        check("skid_full_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check("rst_clears_valid", 32'(out_valid), 32'd0);
        check("rst_ready_low", 32'(in_ready), 32'd0);
        rst = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst2", 32'(in_ready), 32'd1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("no_stale_output", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
